// File: rtl/bht_ctrl.sv
// ---------------------------------------------------------------------------
// bht_ctrl -- branch-history table sequencing controller
//
// Owns a single-port 2^IDX_W x 2-bit counter RAM. After reset it walks the
// whole table writing INIT_VAL. It then arbitrates each cycle between
// fetch-side lookups and queued commit-side updates. Each update is a
// read-modify-write with a 2-bit saturating counter.
//
// Optional feature macro: BHT_STATS_EN
//   When defined, the stat_lookups_o, stat_updates_o and stat_stalls_o
//   counters and ports are added. When undefined, they are absent.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   rdy_i                  global enable; low freezes all state, no table access
//   lk_valid_i/lk_pc_i     lookup request and its PC
//   lk_ready_o             lookup accepted this cycle
//   lk_res_valid_o         prediction valid, one cycle after acceptance
//   lk_taken_o             predicted direction (counter bit 1)
//   upd_valid_i/upd_pc_i/upd_taken_i   committed branch outcome
//   upd_ready_o            update FIFO can accept this cycle
//   tbl_en_o/tbl_we_o/tbl_addr_o/tbl_wdata_o/tbl_rdata_i   counter RAM port
//   init_done_o            initialisation walk complete
//
// States
//   ST_INIT   | walk the table writing INIT_VAL, one entry per rdy cycle
//   ST_IDLE   | serve a lookup, or read the head update's counter
//   ST_UPD_WR | write the saturated counter of the head update and pop it
// ---------------------------------------------------------------------------
module bht_ctrl #(
    parameter int unsigned IDX_W    = 7,
    parameter int unsigned QDEPTH   = 4,
    parameter logic [1:0]  INIT_VAL = 2'b01
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rdy_i,
    input  logic             lk_valid_i,
    input  logic [31:0]      lk_pc_i,
    output logic             lk_ready_o,
    output logic             lk_res_valid_o,
    output logic             lk_taken_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    output logic             tbl_en_o,
    output logic             tbl_we_o,
    output logic [IDX_W-1:0] tbl_addr_o,
    output logic [1:0]       tbl_wdata_o,
    input  logic [1:0]       tbl_rdata_i,
    output logic             init_done_o
`ifdef BHT_STATS_EN
    ,
    output logic [31:0]      stat_lookups_o,
    output logic [31:0]      stat_updates_o,
    output logic [31:0]      stat_stalls_o
`endif
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_WR = 2'd2
    } state_e;

    state_e             state_q, state_d;

    logic [IDX_W-1:0]   init_addr_q;
    logic               init_done_q;
    logic               res_pend_q;

    logic [IDX_W-1:0]   fifo_idx_q [QDEPTH];
    logic               fifo_tkn_q [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               active;
    logic               fifo_full, fifo_empty;
    logic               fifo_push, fifo_pop;
    logic [IDX_W-1:0]   lk_idx, upd_idx, head_idx;
    logic               head_tkn;
    logic [1:0]         upd_new;
    logic               unused_pc_bits;

    // Outputs must show reset values while rst_ni is low, so the enable is
    // qualified by reset as well as rdy.
    assign active     = rdy_i & rst_ni;
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    assign lk_idx   = lk_pc_i[IDX_W+1:2];
    assign upd_idx  = upd_pc_i[IDX_W+1:2];
    assign head_idx = fifo_idx_q[rd_ptr_q];
    assign head_tkn = fifo_tkn_q[rd_ptr_q];

    assign unused_pc_bits = ^{lk_pc_i[31:IDX_W+2], lk_pc_i[1:0],
                              upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

    // Readiness looks only at the registered occupancy: a pop in the same
    // cycle does not open a slot for a full FIFO.
    assign upd_ready_o = active & ~fifo_full;
    assign fifo_push   = upd_valid_i & upd_ready_o;

    assign init_done_o    = init_done_q;
    assign lk_res_valid_o = res_pend_q & rdy_i;
    assign lk_taken_o     = lk_res_valid_o & tbl_rdata_i[1];

    // 2-bit saturating step of the head entry's counter
    always_comb begin
        upd_new = tbl_rdata_i;
        if (head_tkn) begin
            if (tbl_rdata_i != 2'b11) begin
                upd_new = tbl_rdata_i + 2'b01;
            end
        end else if (tbl_rdata_i != 2'b00) begin
            upd_new = tbl_rdata_i - 2'b01;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
        end else if (rdy_i) begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (&init_addr_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (fifo_full) begin
                    state_d = ST_UPD_WR;
                end else if (lk_valid_i) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty) begin
                    state_d = ST_UPD_WR;
                end
            end
            ST_UPD_WR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (table port, lookup handshake, FIFO pop)
    // ---------------------------------------------------------------------
    always_comb begin
        lk_ready_o  = 1'b0;
        tbl_en_o    = 1'b0;
        tbl_we_o    = 1'b0;
        tbl_addr_o  = '0;
        tbl_wdata_o = '0;
        fifo_pop    = 1'b0;
        if (active) begin
            case (state_q)
                ST_INIT: begin
                    tbl_en_o    = 1'b1;
                    tbl_we_o    = 1'b1;
                    tbl_addr_o  = init_addr_q;
                    tbl_wdata_o = INIT_VAL;
                end
                ST_IDLE: begin
                    // A full FIFO outranks lookups so updates cannot starve.
                    if (fifo_full) begin
                        tbl_en_o   = 1'b1;
                        tbl_addr_o = head_idx;
                    end else if (lk_valid_i) begin
                        lk_ready_o = 1'b1;
                        tbl_en_o   = 1'b1;
                        tbl_addr_o = lk_idx;
                    end else if (!fifo_empty) begin
                        tbl_en_o   = 1'b1;
                        tbl_addr_o = head_idx;
                    end
                end
                ST_UPD_WR: begin
                    tbl_en_o    = 1'b1;
                    tbl_we_o    = 1'b1;
                    tbl_addr_o  = head_idx;
                    tbl_wdata_o = upd_new;
                    fifo_pop    = 1'b1;
                end
                default: begin
                    tbl_en_o = 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Init walk, lookup result pending flag, FIFO pointers
    // ---------------------------------------------------------------------
    always_comb begin
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_addr_q <= '0;
            init_done_q <= 1'b0;
            res_pend_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else if (rdy_i) begin
            // Held through rdy-low so the result is re-issued on resume.
            res_pend_q <= lk_ready_o;
            if (state_q == ST_INIT) begin
                init_addr_q <= init_addr_q + 1'b1;
                if (&init_addr_q) begin
                    init_done_q <= 1'b1;
                end
            end
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_idx_q[wr_ptr_q] <= upd_idx;
            fifo_tkn_q[wr_ptr_q] <= upd_taken_i;
        end
    end

`ifdef BHT_STATS_EN
    logic [31:0] stat_lookups_q, stat_updates_q, stat_stalls_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_lookups_q <= '0;
            stat_updates_q <= '0;
            stat_stalls_q  <= '0;
        end else if (rdy_i) begin
            if (lk_ready_o) begin
                stat_lookups_q <= stat_lookups_q + 32'd1;
            end
            if (fifo_pop) begin
                stat_updates_q <= stat_updates_q + 32'd1;
            end
            if (init_done_q && lk_valid_i && !lk_ready_o) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_lookups_o = stat_lookups_q;
    assign stat_updates_o = stat_updates_q;
    assign stat_stalls_o  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_bht_ctrl.sv
module tb_bht_ctrl;

    localparam int IDX_W  = 7;
    localparam int QDEPTH = 4;
    localparam int DEPTH  = 1 << IDX_W;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             rdy_i;
    logic             lk_valid_i;
    logic [31:0]      lk_pc_i;
    logic             lk_ready_o;
    logic             lk_res_valid_o;
    logic             lk_taken_o;
    logic             upd_valid_i;
    logic [31:0]      upd_pc_i;
    logic             upd_taken_i;
    logic             upd_ready_o;
    logic             tbl_en_o;
    logic             tbl_we_o;
    logic [IDX_W-1:0] tbl_addr_o;
    logic [1:0]       tbl_wdata_o;
    logic [1:0]       tbl_rdata_i = 2'b00;
    logic             init_done_o;

    always #5 clk_i = ~clk_i;

    bht_ctrl #(.IDX_W(IDX_W), .QDEPTH(QDEPTH), .INIT_VAL(2'b01)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rdy_i          (rdy_i),
        .lk_valid_i     (lk_valid_i),
        .lk_pc_i        (lk_pc_i),
        .lk_ready_o     (lk_ready_o),
        .lk_res_valid_o (lk_res_valid_o),
        .lk_taken_o     (lk_taken_o),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_ready_o    (upd_ready_o),
        .tbl_en_o       (tbl_en_o),
        .tbl_we_o       (tbl_we_o),
        .tbl_addr_o     (tbl_addr_o),
        .tbl_wdata_o    (tbl_wdata_o),
        .tbl_rdata_i    (tbl_rdata_i),
        .init_done_o    (init_done_o)
    );

    // Single-port counter RAM: read data appears the cycle after a read and
    // holds until the next access.
    logic [1:0] mem [DEPTH];
    always @(posedge clk_i) begin
        if (tbl_en_o) begin
            if (tbl_we_o) mem[tbl_addr_o] <= tbl_wdata_o;
            else          tbl_rdata_i     <= mem[tbl_addr_o];
        end
    end

    // Reference: counter values per index, pending updates in acceptance
    // order, and expected predictions of accepted lookups.
    typedef struct { int idx; bit tkn; } upd_t;
    int   ref_tbl [DEPTH];
    upd_t upd_q [$];
    bit   exp_lk_q [$];
    upd_t mu;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int sat_next(input int v, input bit t);
        if (t) return (v + 1 > 3) ? 3 : v + 1;
        return (v - 1 < 0) ? 0 : v - 1;
    endfunction

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'(DEPTH - 1));
    endfunction

    function automatic logic [31:0] rnd_pc();
        logic [31:0] r;
        int          idx;
        r   = $urandom;
        idx = ($urandom_range(0, 9) == 0) ? DEPTH - 1 : int'($urandom_range(0, 7));
        return (r & 32'hFFFF_FE03) | 32'(idx << 2);
    endfunction

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            upd_q.delete();
            exp_lk_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 1;
        end else if (!rdy_i) begin
            chk("stall_tbl_en", tbl_en_o, 0);
            chk("stall_res_valid", lk_res_valid_o, 0);
            chk("stall_lk_ready", lk_ready_o, 0);
            chk("stall_upd_ready", upd_ready_o, 0);
        end else begin
            chk("upd_ready", upd_ready_o, upd_q.size() < QDEPTH);
            if (upd_q.size() == QDEPTH) chk("full_priority", lk_ready_o, 0);
            if (!init_done_o) chk("init_no_lookup", lk_ready_o, 0);
            if (lk_res_valid_o) begin
                if (exp_lk_q.size() == 0) chk("spurious_result", exp_lk_q.size(), 1);
                else chk("lk_taken", lk_taken_o, exp_lk_q.pop_front());
            end
            if (tbl_en_o && tbl_we_o && init_done_o) begin
                if (upd_q.size() == 0) begin
                    chk("spurious_write", upd_q.size(), 1);
                end else begin
                    mu = upd_q.pop_front();
                    chk("upd_addr", tbl_addr_o, mu.idx);
                    chk("upd_wdata", tbl_wdata_o, sat_next(ref_tbl[mu.idx], mu.tkn));
                    ref_tbl[mu.idx] = sat_next(ref_tbl[mu.idx], mu.tkn);
                end
            end
            if (lk_ready_o) begin
                chk("lk_read", {tbl_en_o, tbl_we_o}, 2'b10);
                chk("lk_addr", tbl_addr_o, pc_idx(lk_pc_i));
                exp_lk_q.push_back(ref_tbl[pc_idx(lk_pc_i)] >= 2);
            end
            if (upd_valid_i && upd_ready_o) upd_q.push_back('{pc_idx(upd_pc_i), upd_taken_i});
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_lk_ready"}, lk_ready_o, 0);
        chk({p, "_lk_res_valid"}, lk_res_valid_o, 0);
        chk({p, "_lk_taken"}, lk_taken_o, 0);
        chk({p, "_upd_ready"}, upd_ready_o, 0);
        chk({p, "_tbl_en"}, tbl_en_o, 0);
        chk({p, "_tbl_we"}, tbl_we_o, 0);
        chk({p, "_tbl_addr"}, tbl_addr_o, 0);
        chk({p, "_tbl_wdata"}, tbl_wdata_o, 0);
        chk({p, "_init_done"}, init_done_o, 0);
    endtask

    task automatic wait_upd_wr(input string tag);
        int n = 0;
        #1;
        while (!(tbl_en_o && tbl_we_o && init_done_o) && n < 50) begin
            step();
            n++;
        end
        chk(tag, n < 50, 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rdy_i = 1'b1; lk_valid_i = 1'b0; upd_valid_i = 1'b0;
        while ((upd_q.size() != 0 || exp_lk_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        chk(tag, n < 200, 1);
    endtask

    task automatic enq(input logic [31:0] pc, input bit t);
        int n = 0;
        upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = t;
        #1;
        while (!upd_ready_o && n < 50) begin
            step();
            n++;
        end
        chk("enq_timeout", n < 50, 1);
        step();
        upd_valid_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input bit exp, input string tag);
        int n = 0;
        lk_valid_i = 1'b1; lk_pc_i = pc;
        #1;
        while (!lk_ready_o && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_accept"}, n < 50, 1);
        step();
        lk_valid_i = 1'b0;
        chk({tag, "_valid"}, lk_res_valid_o, 1);
        chk(tag, lk_taken_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_w;
        rst_ni = 1'b0; rdy_i = 1'b1;
        lk_valid_i = 1'b0; lk_pc_i = '0;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
        #1;
        chk_reset("rst");
        step(); step();

        // Init walk: 128 writes of 01 to 0..127, init_done in the next cycle
        rst_ni = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("init_we", {tbl_en_o, tbl_we_o}, 2'b11);
            chk("init_addr", tbl_addr_o, i);
            chk("init_wdata", tbl_wdata_o, 2'b01);
            chk("init_done_low", init_done_o, 0);
            step();
        end
        chk("init_done", init_done_o, 1);
        lookup(32'h100, 1'b0, "lk_after_init");

        // Saturation up then down on entry 16
        for (int k = 0; k < 4; k++) enq(32'h40, 1'b1);
        drain("drain_sat_up");
        chk("sat_up_mem", mem[16], 3);
        lookup(32'h40, 1'b1, "lk_sat_up");
        for (int k = 0; k < 4; k++) enq(32'h40, 1'b0);
        drain("drain_sat_dn");
        chk("sat_dn_mem", mem[16], 0);
        lookup(32'h40, 1'b0, "lk_sat_dn");

        // Full-FIFO priority with lookups held continuously
        lk_valid_i = 1'b1; lk_pc_i = 32'h200; upd_valid_i = 1'b1; upd_taken_i = 1'b1;
        for (int k = 0; k < QDEPTH; k++) begin
            upd_pc_i = 32'h80 + 32'(4 * k);
            #1;
            chk("ff_upd_ready", upd_ready_o, 1);
            chk("ff_lk_ready", lk_ready_o, 1);
            step();
        end
        upd_valid_i = 1'b0;
        chk("ff_full", upd_ready_o, 0);
        chk("ff_prio_lk", lk_ready_o, 0);
        chk("ff_rd", {tbl_en_o, tbl_we_o}, 2'b10);
        chk("ff_rd_addr", tbl_addr_o, 32);
        step();
        chk("ff_wr", {tbl_en_o, tbl_we_o}, 2'b11);
        chk("ff_wr_lk", lk_ready_o, 0);
        step();
        chk("ff_resume_lk", lk_ready_o, 1);
        chk("ff_resume_upd", upd_ready_o, 1);

        // Enqueue during a pop leaves occupancy unchanged (3 stays 3)
        lk_valid_i = 1'b0;
        wait_upd_wr("sim_timeout");
        upd_valid_i = 1'b1; upd_pc_i = 32'h300; upd_taken_i = 1'b0;
        #1;
        chk("sim_upd_ready", upd_ready_o, 1);
        step();
        upd_valid_i = 1'b0; lk_valid_i = 1'b1; lk_pc_i = 32'h104;
        #1;
        chk("sim_occ_not_full", upd_ready_o, 1);
        upd_valid_i = 1'b1; upd_pc_i = 32'h304; upd_taken_i = 1'b1;
        step();
        upd_valid_i = 1'b0;
        chk("sim_occ_full", upd_ready_o, 0);
        drain("drain_sim");

        // rdy stall inside UPD_WR
        upd_valid_i = 1'b1; upd_pc_i = 32'h44; upd_taken_i = 1'b1;
        step();
        upd_valid_i = 1'b0;
        wait_upd_wr("stl_timeout");
        exp_w = sat_next(ref_tbl[17], 1'b1);
        rdy_i = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stl_tbl_en", tbl_en_o, 0);
            step();
        end
        rdy_i = 1'b1;
        #1;
        chk("stl_wr", {tbl_en_o, tbl_we_o}, 2'b11);
        chk("stl_addr", tbl_addr_o, 17);
        chk("stl_wdata", tbl_wdata_o, exp_w);
        step();

        // rdy stall between lookup acceptance and result
        lk_valid_i = 1'b1; lk_pc_i = 32'h44;
        #1;
        chk("ls_accept", lk_ready_o, 1);
        step();
        lk_valid_i = 1'b0; rdy_i = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("ls_hold", lk_res_valid_o, 0);
            step();
        end
        rdy_i = 1'b1;
        #1;
        chk("ls_result", lk_res_valid_o, 1);
        chk("ls_taken", lk_taken_o, exp_w >= 2);
        step();

        // Randomised traffic against the reference
        for (int c = 0; c < 800; c++) begin
            rdy_i       = ($urandom_range(0, 9) != 0);
            lk_valid_i  = ($urandom_range(0, 2) != 0);
            lk_pc_i     = rnd_pc();
            upd_valid_i = ($urandom_range(0, 1) != 0);
            upd_pc_i    = rnd_pc();
            upd_taken_i = ($urandom_range(0, 1) != 0);
            step();
        end
        drain("drain_random");

        // Reset while in UPD_WR with three updates queued
        lk_valid_i = 1'b1; lk_pc_i = 32'h0;
        for (int k = 0; k < 3; k++) begin
            upd_valid_i = 1'b1; upd_pc_i = 32'h400 + 32'(4 * k); upd_taken_i = 1'b0;
            #1;
            chk("mr_fill_ready", upd_ready_o, 1);
            step();
        end
        upd_valid_i = 1'b0; lk_valid_i = 1'b0;
        wait_upd_wr("mr_timeout");
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_reset("mr");
        step(); step();
        rst_ni = 1'b1;
        #1;
        chk("mr_restart_we", {tbl_en_o, tbl_we_o}, 2'b11);
        chk("mr_restart_addr", tbl_addr_o, 0);
        // FIFO must be empty again: exactly four more entries fit
        for (int k = 0; k < QDEPTH; k++) begin
            upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1;
            #1;
            chk("mr_q_ready", upd_ready_o, 1);
            chk("mr_q_init", init_done_o, 0);
            step();
        end
        upd_valid_i = 1'b0;
        chk("mr_q_full", upd_ready_o, 0);
        n = 0;
        while (!init_done_o && n < 200) begin
            step();
            n++;
        end
        chk("mr_init_timeout", n < 200, 1);
        drain("drain_mr");
        chk("mr_sat_mem", mem[16], 3);
        lookup(32'h40, 1'b1, "lk_after_mr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bht_ctrl.md
# bht_ctrl

Sequencing controller for the branch-history table (BHT) behind the instruction fetcher. It owns a single-port 2^IDX_W × 2-bit counter RAM and walks it to a known value after reset. It arbitrates each cycle between fetch-side lookups and ROB-side commit updates, buffering updates in a small FIFO and performing each one as a read-modify-write with 2-bit saturating arithmetic.

## Interface
- IDX_W, 7: table index width; the table holds 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- QDEPTH, 4: depth of the update FIFO; must be a power of two, at least 2.
- INIT_VAL, 2'b01: counter value written to every entry during initialisation.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; while low, no state changes and no table access.
- lk_valid  in  1  fetcher requests a prediction.
- lk_pc  in  32  PC to predict.
- lk_ready  out  1  lookup accepted this cycle.
- lk_res_valid  out  1  prediction valid; pulses one cycle after acceptance.
- lk_taken  out  1  predicted direction (counter bit 1).
- upd_valid  in  1  ROB commits a branch outcome.
- upd_pc  in  32  PC of the committed branch.
- upd_taken  in  1  actual outcome of the committed branch.
- upd_ready  out  1  FIFO can accept an update this cycle.
- tbl_en  out  1  table access enable.
- tbl_we  out  1  write (1) or read (0).
- tbl_addr  out  IDX_W  table index.
- tbl_wdata  out  2  write data.
- tbl_rdata  in  2  read data, valid the cycle after a read; held stable until the next tbl_en.
- init_done  out  1  initialisation walk complete.

## Operation
- States: INIT, IDLE, UPD_WR.
- INIT:
  - Write INIT_VAL to init_addr each rdy cycle, incrementing from 0.
  - After writing 2^IDX_W−1, go to IDLE and set init_done.
  - lk_ready = 0 throughout.
  - upd_ready still follows the FIFO, so updates may queue during init.
- IDLE, with priority per cycle (rdy high):
  1. FIFO full: issue a read of the head index, go to UPD_WR, lk_ready = 0.
  2. Otherwise, if lk_valid: lk_ready = 1 and read index lk_pc[IDX_W+1:2]. Next cycle lk_res_valid = 1 and lk_taken = tbl_rdata[1].
  3. Otherwise, if the FIFO is not empty: read the head index and go to UPD_WR.
- UPD_WR:
  - Compute new = upd_taken ? min(rdata+1, 3) : max(rdata−1, 0), from the head entry.
  - Write new, pop the FIFO, return to IDLE.
  - lk_ready = 0.
- FIFO:
  - Entries are {index, taken}.
  - upd_ready = rdy & ~full. Enqueue when upd_valid & upd_ready.
  - There is no same-cycle pass-through when full, even if a pop occurs that cycle.
  - Enqueue and pop in the same cycle are both honoured.
- No write-to-lookup forwarding is needed, because a lookup is never issued in UPD_WR.
- Index arithmetic is unsigned. init_addr and the FIFO pointers wrap modulo their size.

## Timing
- Reset values:
  - state = INIT, init_addr = 0, FIFO empty, init_done = 0.
  - lk_ready = 0, lk_res_valid = 0, lk_taken = 0, upd_ready = 0.
  - tbl_en = 0, tbl_we = 0, tbl_addr = 0, tbl_wdata = 0.
- Reset asserted mid-operation: all of the above are restored immediately; queued updates are discarded.
- Initialisation takes 2^IDX_W rdy-high cycles. init_done rises in the cycle after the last write.
- Lookup latency is 1 cycle from acceptance to lk_res_valid.
- Lookup throughput is 1 per cycle while the FIFO is not full.
- Each update occupies the table for 2 cycles (IDLE read, then UPD_WR write).
- rdy low:
  - All registers hold; tbl_en = 0.
  - lk_res_valid is held low and is re-issued on resume. The pending result is still taken from the held tbl_rdata.

## Configuration
- BHT_STATS_EN defined:
  - Adds outputs stat_lookups[31:0], stat_updates[31:0] and stat_stalls[31:0].
  - They count, respectively: accepted lookups, completed UPD_WR writes, and cycles with lk_valid & ~lk_ready after init_done.
  - All three reset to 0 and wrap on overflow.
- Undefined: the three ports and their counters are absent. Behaviour is otherwise identical.

## Test plan
- Init walk: release reset with rdy = 1, IDX_W = 7.
  - Expect exactly 128 writes of 2'b01 to addresses 0..127.
  - init_done rises in cycle 129.
  - A lookup of pc 0x100 then returns lk_taken = 0.
- Saturation: enqueue 4 updates at pc 0x40, all taken.
  - Entry 16 steps 1→2→3→3; lookup gives lk_taken = 1.
  - Then 4 not-taken updates step 3→2→1→0→0; lookup gives lk_taken = 0.
- Full-FIFO priority: hold lk_valid = 1 continuously and enqueue 4 updates.
  - upd_ready drops after the fourth.
  - The next IDLE cycle has lk_ready = 0 and an update read.
  - Lookups resume once the FIFO is no longer full.
- Simultaneous events: upd_valid on the same cycle as a pop.
  - Both are honoured; occupancy is unchanged.
- rdy stall: drop rdy in UPD_WR for 3 cycles.
  - No tbl_en during the stall.
  - The write completes with the correct value after resume.
- Mid-operation reset: assert rst = 0 with 3 updates queued in UPD_WR.
  - All outputs return to reset values asynchronously.
  - The queued updates are lost and the init walk restarts at 0.
